timer_counter: RTL

//  Memory-mapped down-counting timer on the system bridge; drives one hwint line of CP0 (hwint[0]).

---
 rtl/timer_counter_if.sv | 35 +++
 rtl/timer_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// Bus-side signal bundle for the memory-mapped down-counting timer.
//
// Signals
//   addr   word select (bus byte address[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we     write strobe, sampled at the rising clock edge
//   wdata  write data
//   rdata  read data, combinational from addr
//   irq    interrupt request toward CP0 hwint[0]
//
// Modports
//   master  system bridge / CPU side: drives addr, we, wdata
//   slave   timer side: drives rdata and irq
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer driving one CP0 hardware interrupt line.
//
// Software programs PRESET and CTRL over the bus; once enabled the timer loads
// PRESET into COUNT, counts down to zero and then raises a pending interrupt.
//   Mode 0 (one-shot):    irq is a level held until software writes CTRL or PRESET;
//                         hardware clears EN when the count expires.
//   Mode 1 (auto-reload): irq is a one-cycle pulse and the counter reloads.
//
// Ports
//   clk    system clock, all state changes on the rising edge
//   clr_n  asynchronous active-low reset
//   bus    timer_counter_if slave modport (addr, we, wdata, rdata, irq)
//
// Register map
//   0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot), [3] IM
//   1 PRESET read/write reload value
//   2 COUNT  read-only current count
//   3 reserved, reads 0, writes ignored
module timer_counter #(
    parameter int          CNT_WIDTH = 32,
    parameter logic [3:0]  CTRL_RST  = 4'h0
) (
    input  logic            clk,
    input  logic            clr_n,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t                 state;
    logic [3:0]             ctrl;
    logic [CNT_WIDTH-1:0]   preset;
    logic [CNT_WIDTH-1:0]   count;
    logic                   irq_pend;

    logic                   ctrl_wr;
    logic                   preset_wr;
    logic                   ctrl_en;
    logic                   mode_reload;

    assign ctrl_wr     = bus.we && (bus.addr == 2'd0);
    assign preset_wr   = bus.we && (bus.addr == 2'd1);
    assign ctrl_en     = ctrl[0];
    assign mode_reload = (ctrl[2:1] == 2'b01);

    // Interrupt is the pending flag gated by the mask; masking never clears
    // the pending flag itself.
    assign bus.irq = ctrl[3] & irq_pend;

    // Read mux; narrower counters are zero-extended onto the 32-bit bus.
    always_comb begin
        bus.rdata = 32'h0;
        case (bus.addr)
            2'd0:    bus.rdata = {28'h0, ctrl};
            2'd1:    bus.rdata = 32'(preset);
            2'd2:    bus.rdata = 32'(count);
            default: bus.rdata = 32'h0;
        endcase
    end

    // Register file and counting FSM. Statement order matters: the bus write
    // and acknowledge come first so that a later hardware assignment in the
    // same edge wins where intended (irq_pend set beats the acknowledge),
    // while the one-shot EN clear is skipped when software writes CTRL in
    // that same cycle so the written value survives.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            ctrl     <= CTRL_RST;
            preset   <= '0;
            count    <= '0;
            irq_pend <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= bus.wdata[3:0];
            end
            if (preset_wr) begin
                preset <= CNT_WIDTH'(bus.wdata);
            end
            if (ctrl_wr || preset_wr) begin
                irq_pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= preset;
                        state <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > CNT_WIDTH'(1)) begin
                        count <= count - CNT_WIDTH'(1);
                    end else begin
                        // A preset of 0 lands here too, giving the same
                        // timing as a preset of 1.
                        count    <= '0;
                        irq_pend <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode_reload) begin
                        irq_pend <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        if (!ctrl_wr) begin
                            ctrl[0] <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
